// File: rtl/keypad_pkg.sv
// ============================================================================
// keypad_pkg: shared types, constants and helpers for the 4x4 keypad scanner.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package keypad_pkg;

  localparam int         NUM_ROWS  = 4;
  localparam int         NUM_COLS  = 4;
  localparam logic [3:0] START_KEY = 4'd15;

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_e;

  // Lowest-numbered active-low row wins when several are pressed together.
  function automatic logic [1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows_n);
    lowest_low_row = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows_n[i]) lowest_low_row = 2'(i);
    end
  endfunction

  function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
    col_drive = ~(4'b0001 << idx);
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_debounce.sv
// ============================================================================
// keypad_debounce: saturating stable-level counter shared by press and release.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module keypad_debounce #(
  parameter int CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic done_o
);

  localparam int            CW       = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any break in the level restarts the count from zero.
  always_comb begin
    cnt_d = '0;
    if (level_i) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign done_o = level_i && (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/keypad_scan.sv
// ============================================================================
// keypad_scan: 4x4 column-scanned keypad with debounced press/release.
// Optional KEYPAD_START_KEY_EN: key 15 pulses start instead of key_en.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_en,
  output logic [3:0] key_index,
  output logic       start
);

  localparam int            DW       = $clog2(SCAN_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]    sync1_q, sync2_q;
  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic          key_en_q, key_en_d;
  logic [3:0]    key_index_q, key_index_d;
  logic          start_d;

  logic       row_low;
  logic       slot_end;
  logic       deb_level;
  logic       deb_done;
  logic [3:0] code;

  assign row_low   = !sync2_q[row_q];
  assign slot_end  = (div_q == DIV_LAST);
  assign code      = {row_q, col_q};
  assign deb_level = ((state_q == DEB_PRESS) && row_low) ||
                     ((state_q == DEB_RELEASE) && !row_low);

  keypad_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .level_i (deb_level),
    .done_o  (deb_done)
  );

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    col_d       = col_q;
    row_d       = row_q;
    key_en_d    = 1'b0;
    start_d     = 1'b0;
    key_index_d = key_index_q;
    case (state_q)
      SCAN: begin
        if (slot_end) begin
          div_d = '0;
          if (!(&sync2_q)) begin
            row_d   = lowest_low_row(sync2_q);
            state_d = DEB_PRESS;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DEB_PRESS: begin
        // A bounce rescans the same column from the start of its slot.
        if (!row_low) begin
          state_d = SCAN;
          div_d   = '0;
        end else if (deb_done) begin
          state_d = HELD;
`ifdef KEYPAD_START_KEY_EN
          if (code == START_KEY) begin
            start_d = 1'b1;
          end else begin
            key_en_d    = 1'b1;
            key_index_d = code;
          end
`else
          key_en_d    = 1'b1;
          key_index_d = code;
`endif
        end
      end
      HELD: begin
        if (!row_low) state_d = DEB_RELEASE;
      end
      DEB_RELEASE: begin
        if (row_low) begin
          state_d = HELD;
        end else if (deb_done) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          div_d   = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      state_q     <= SCAN;
      div_q       <= '0;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      key_en_q    <= 1'b0;
      key_index_q <= 4'd0;
    end else begin
      sync1_q     <= row_n;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      div_q       <= div_d;
      col_q       <= col_d;
      row_q       <= row_d;
      key_en_q    <= key_en_d;
      key_index_q <= key_index_d;
    end
  end

`ifdef KEYPAD_START_KEY_EN
  logic start_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) start_q <= 1'b0;
    else      start_q <= start_d;
  end

  assign start = start_q;
`else
  logic unused_start;
  assign unused_start = start_d;
  assign start        = 1'b0;
`endif

  assign col_n     = col_drive(col_q);
  assign key_en    = key_en_q;
  assign key_index = key_index_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan.sv
// ============================================================================
// tb_keypad_scan: directed self-checking bench for keypad_scan (SCAN_DIV=4, DEBOUNCE=8).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row_n = 4'b1111;
  logic [3:0] col_n;
  logic       key_en;
  logic [3:0] key_index;
  logic       start;

  int compared   = 0;
  int mismatched = 0;
  int en_cnt     = 0;
  int st_cnt     = 0;

  keypad_scan #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_en    (key_en),
    .key_index (key_index),
    .start     (start)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_en === 1'b1) en_cnt++;
    if (start === 1'b1)  st_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns at the first sample of a fresh slot for the target column.
  task automatic wait_slot(input logic [3:0] target, output int ok);
    int n;
    n = 0;
    while (col_n === target && n < 100) begin tick(1); n++; end
    while (col_n !== target && n < 100) begin tick(1); n++; end
    ok = (col_n === target) ? 1 : 0;
  endtask

  task automatic wait_pulse(input int limit, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (key_en !== 1'b1 && start !== 1'b1 && n < limit);
    if (key_en !== 1'b1 && start !== 1'b1) n = -1;
  endtask

  task automatic wait_col_change(input logic [3:0] from, input int limit, output int n);
    n = 0;
    while (col_n === from && n < limit) begin tick(1); n++; end
    if (col_n === from) n = -1;
  endtask

  initial begin
    int ok, n, m, bad, base, sbase;
    logic [3:0] v;

    // Reset state
    rst = 1'b0;
    tick(3);
    check("rst_col_n", 32'(col_n), 32'hE);
    check("rst_key_en", 32'(key_en), 32'h0);
    check("rst_key_index", 32'(key_index), 32'h0);
    check("rst_start", 32'(start), 32'h0);
    rst = 1'b1;

    // Idle scan rotation, SCAN_DIV cycles per column
    wait_col_change(4'b1110, 20, n);
    check("idle_first_change", 32'(n > 0), 32'h1);
    check("idle_first_col", 32'(col_n), 32'hD);
    v = col_n;
    for (int k = 0; k < 4; k++) begin
      tick(SCAN_DIV - 1);
      check("idle_slot_hold", 32'(col_n), 32'(v));
      tick(1);
      check("idle_rotate", 32'(col_n), 32'({v[2:0], v[3]}));
      v = col_n;
    end
    check("idle_no_key_en", 32'(en_cnt), 32'h0);

    // Key 9: row 2 on column 1, long hold
    wait_slot(4'b1101, ok);
    check("k9_slot_found", 32'(ok), 32'h1);
    base = en_cnt;
    row_n = 4'b1011;
    wait_pulse(30, n);
    check("k9_latency_ok", 32'(n >= DEB + 2 && n <= DEB + 4), 32'h1);
    check("k9_key_index", 32'(key_index), 32'h9);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (col_n !== 4'b1101) bad++;
    end
    check("k9_col_frozen", 32'(bad), 32'h0);
    check("k9_single_pulse", 32'(en_cnt - base), 32'h1);
    row_n = 4'b1111;
    wait_col_change(4'b1101, 40, m);
    check("k9_release_time_ok", 32'(m >= DEB + 2 && m <= DEB + 4), 32'h1);
    check("k9_resume_col2", 32'(col_n), 32'hB);
    check("k9_no_release_pulse", 32'(en_cnt - base), 32'h1);

    // 5-cycle glitch on row 0, column 3
    wait_slot(4'b0111, ok);
    check("glitch_slot_found", 32'(ok), 32'h1);
    base = en_cnt;
    row_n = 4'b1110;
    tick(5);
    row_n = 4'b1111;
    n = 0;
    while (col_n !== 4'b1110 && n < 30) begin tick(1); n++; end
    check("glitch_scan_resumes", 32'(col_n), 32'hE);
    check("glitch_no_key_en", 32'(en_cnt - base), 32'h0);
    check("glitch_index_kept", 32'(key_index), 32'h9);

    // Key 6 with a short release bounce
    wait_slot(4'b1011, ok);
    check("k6_slot_found", 32'(ok), 32'h1);
    base = en_cnt;
    row_n = 4'b1101;
    wait_pulse(30, n);
    check("k6_pulse_seen", 32'(n > 0), 32'h1);
    check("k6_key_index", 32'(key_index), 32'h6);
    tick(10);
    row_n = 4'b1111;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      if (col_n !== 4'b1011) bad++;
    end
    row_n = 4'b1101;
    tick(20);
    if (col_n !== 4'b1011) bad++;
    check("k6_bounce_col_frozen", 32'(bad), 32'h0);
    row_n = 4'b1111;
    wait_col_change(4'b1011, 40, m);
    check("k6_release_time_ok", 32'(m >= DEB + 2 && m <= DEB + 4), 32'h1);
    check("k6_resume_col3", 32'(col_n), 32'h7);
    check("k6_single_pulse", 32'(en_cnt - base), 32'h1);

    // Key 15: row 3 on column 3
    wait_slot(4'b0111, ok);
    check("k15_slot_found", 32'(ok), 32'h1);
    base = en_cnt;
    sbase = st_cnt;
    row_n = 4'b0111;
    wait_pulse(30, n);
    check("k15_pulse_seen", 32'(n > 0), 32'h1);
    tick(3);
`ifdef KEYPAD_START_KEY_EN
    check("k15_start_once", 32'(st_cnt - sbase), 32'h1);
    check("k15_no_key_en", 32'(en_cnt - base), 32'h0);
    check("k15_index_unchanged", 32'(key_index), 32'h6);
`else
    check("k15_key_en_once", 32'(en_cnt - base), 32'h1);
    check("k15_no_start", 32'(st_cnt - sbase), 32'h0);
    check("k15_key_index", 32'(key_index), 32'hF);
`endif
    row_n = 4'b1111;
    wait_col_change(4'b0111, 40, m);
    check("k15_resume_col0", 32'(col_n), 32'hE);

    // Rows 1 and 3 on column 0, then reset while held
    wait_slot(4'b1110, ok);
    check("k4_slot_found", 32'(ok), 32'h1);
    row_n = 4'b0101;
    wait_pulse(30, n);
    check("k4_pulse_seen", 32'(n > 0), 32'h1);
    check("k4_lowest_row_wins", 32'(key_index), 32'h4);
    tick(5);
    rst = 1'b0;
    tick(2);
    check("held_rst_col_n", 32'(col_n), 32'hE);
    check("held_rst_key_en", 32'(key_en), 32'h0);
    check("held_rst_key_index", 32'(key_index), 32'h0);
    check("held_rst_start", 32'(start), 32'h0);
    base = en_cnt;
    rst = 1'b1;
    wait_pulse(40, n);
    check("k4_redetect_latency_ok", 32'(n >= DEB + 2 && n <= DEB + 6), 32'h1);
    check("k4_redetect_index", 32'(key_index), 32'h4);
    tick(20);
    check("k4_redetect_once", 32'(en_cnt - base), 32'h1);
    row_n = 4'b1111;
    wait_col_change(4'b1110, 40, m);
    check("k4_resume_col1", 32'(col_n), 32'hD);

    // Reset during press debounce drops the pending pulse
    wait_slot(4'b1101, ok);
    check("k1_slot_found", 32'(ok), 32'h1);
    base = en_cnt;
    row_n = 4'b1110;
    tick(7);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    row_n = 4'b1111;
    tick(20);
    check("deb_rst_no_pulse", 32'(en_cnt - base), 32'h0);
    check("deb_rst_index", 32'(key_index), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000, SHALL set the clock cycles each column is driven before advancing the scan.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000, SHALL set the stable-level cycles needed to confirm a press or a release.
REQ-003 Port clk, input, 1 bit: single system clock; all state SHALL be in this domain.
REQ-004 Port rst, input, 1 bit: reset, asynchronous assert, active-low (0 = reset).
REQ-005 Port row_n, input, 4 bits: keypad rows, active-low, asynchronous to clk.
REQ-006 Port col_n, output, 4 bits: keypad column drive, active-low one-hot; only one bit is 0 at a time.
REQ-007 Port key_en, output, 1 bit: one-cycle pulse for each confirmed press.
REQ-008 Port key_index, output, 4 bits: code of the last confirmed key, equal to row*4+col; held between pulses.
REQ-009 Port start, output, 1 bit: one-cycle start pulse (see Configuration).

Function
REQ-010 row_n SHALL pass through a 2-FF synchronizer; all logic SHALL use only the synchronized value.
REQ-011 States SHALL be SCAN, DEB_PRESS, HELD and DEB_RELEASE.
REQ-012 In SCAN, col_n SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing once every SCAN_DIV cycles.
REQ-013 In SCAN, any synchronized row low in the last cycle of a column slot SHALL latch the row and column and enter DEB_PRESS; the column drive SHALL freeze.
REQ-014 If several rows are low together, the lowest row number SHALL win.
REQ-015 In DEB_PRESS, the counter SHALL increment while the latched row stays low and SHALL return to SCAN the next cycle if that row goes high.
REQ-016 When the counter reaches DEBOUNCE_CYCLES-1: enter HELD, update key_index, and pulse key_en (or start) for exactly one cycle on the following cycle.
REQ-017 In HELD, col_n SHALL stay frozen and no further pulses SHALL occur, whatever the hold length or other keys pressed.
REQ-018 In HELD, the latched row going high SHALL enter DEB_RELEASE.
REQ-019 DEB_RELEASE SHALL require DEBOUNCE_CYCLES consecutive high cycles on the latched row, then resume SCAN at the next column.
REQ-020 In DEB_RELEASE, the row going low again SHALL return to HELD with no new pulse.
REQ-021 Counter widths SHALL be $clog2(parameter+1); the counters SHALL saturate and never wrap.
REQ-022 Latency from a stable press in the active column to key_en SHALL be DEBOUNCE_CYCLES+3 cycles (2 sync + 1 output register), within ±1 cycle.

Reset
REQ-023 While rst=0: state=SCAN, col_n=4'b1110, key_en=0, start=0, key_index=0, counters=0, synchronizer=4'b1111.
REQ-024 Reset asserted mid-debounce or in HELD SHALL drop any pending pulse; after release, a held key SHALL be re-detected and debounced from zero.

Configuration
REQ-025 When macro KEYPAD_START_KEY_EN is defined, key 15 SHALL pulse start instead of key_en and SHALL NOT update key_index; keys 0-14 SHALL behave as normal.
REQ-026 When KEYPAD_START_KEY_EN is undefined, start SHALL be tied to 0 and key 15 SHALL behave like any other key.

Structure
REQ-027 Package keypad_pkg SHALL hold the state enum, NUM_ROWS=4, NUM_COLS=4 and START_KEY=4'd15.
REQ-028 One sub-module, keypad_debounce, SHALL hold the saturating stable-level counter; it is reused for press and release.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-029 Reset then idle rows=1111 -> col_n cycles through 1110/1101/1011/0111 every 4 clk; key_en never asserts.
REQ-030 Hold row 2 low while col 1 is active -> one key_en pulse with key_index=9; col_n held at 1101 until release.
REQ-031 Row 0 low for 5 cycles (a glitch) on col 3 -> no key_en; scanning resumes.
REQ-032 Press key 6, release for 4 cycles, re-press, then release for good -> exactly one key_en; after 8 high cycles scanning resumes at col 3.
REQ-033 Key 15 with KEYPAD_START_KEY_EN defined -> start pulses once, key_en=0, key_index unchanged; with it undefined -> key_en pulses, key_index=15.
REQ-034 Rows 1 and 3 low on col 0 -> key_index=4; rst=0 pulse during HELD -> outputs reset; key re-reported once after DEBOUNCE.
